// File: rtl/reorder_buffer.sv
// -----------------------------------------------------------------------------
// reorder_buffer
//
// Circular in-order retirement buffer for the Tomasulo core. It sits between
// issue / common data bus (CDB) and the register file:
//   * allocates one entry per issued instruction (id = current tail),
//   * captures results broadcast on the CDB,
//   * retires the head entry in program order through the register-file commit
//     port, or as a store-commit pulse towards the store buffer,
//   * detects branch mispredictions at retirement and raises a one-cycle,
//     pipeline-wide clear together with the redirect PC.
//
// Parameters
//   ROB_INDEX_BIT       entry-index width, depth = 2**ROB_INDEX_BIT
//
// Ports
//   clk_in              system clock
//   rst_in              synchronous reset, active low
//   rdy_in              global enable; when low every register holds
//   issue_valid         allocate an entry this cycle (dropped while full)
//   issue_type          0 = register-write op, 1 = store, 2 = branch/jump
//   issue_rd            destination register, 0 = none
//   issue_pred_taken    predicted direction (branches)
//   issue_ready         result already known at issue
//   issue_value         that result
//   issue_rob_id        id handed to the issuing instruction (= tail), comb.
//   full                all entries occupied, comb.
//   cdb_valid           CDB writeback strobe
//   cdb_rob_id          writeback target entry
//   cdb_value           writeback result
//   cdb_taken           resolved branch direction
//   cdb_target          resolved next PC
//   qry_id1/2           operand dependency lookups from issue
//   qry_ready1/2        queried entry has (or is receiving) its result, comb.
//   qry_value1/2        queried entry's result, CDB-bypassed, comb.
//   set_value_id        register-file commit target, 0 = no write (reg.)
//   set_value           register-file commit value (reg.)
//   set_value_rob_id    id of the committing entry (reg.)
//   commit_store        one-cycle pulse when a store retires (reg.)
//   commit_store_rob_id id of that store (reg.)
//   clear               one-cycle misprediction flush (reg.)
//   clear_pc            redirect PC, valid with clear (reg.)
// -----------------------------------------------------------------------------
module reorder_buffer #(
    parameter int ROB_INDEX_BIT = 3
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,

    input  logic                     issue_valid,
    input  logic [1:0]               issue_type,
    input  logic [4:0]               issue_rd,
    input  logic                     issue_pred_taken,
    input  logic                     issue_ready,
    input  logic [31:0]              issue_value,
    output logic [ROB_INDEX_BIT-1:0] issue_rob_id,
    output logic                     full,

    input  logic                     cdb_valid,
    input  logic [ROB_INDEX_BIT-1:0] cdb_rob_id,
    input  logic [31:0]              cdb_value,
    input  logic                     cdb_taken,
    input  logic [31:0]              cdb_target,

    input  logic [ROB_INDEX_BIT-1:0] qry_id1,
    input  logic [ROB_INDEX_BIT-1:0] qry_id2,
    output logic                     qry_ready1,
    output logic                     qry_ready2,
    output logic [31:0]              qry_value1,
    output logic [31:0]              qry_value2,

    output logic [4:0]               set_value_id,
    output logic [31:0]              set_value,
    output logic [ROB_INDEX_BIT-1:0] set_value_rob_id,
    output logic                     commit_store,
    output logic [ROB_INDEX_BIT-1:0] commit_store_rob_id,
    output logic                     clear,
    output logic [31:0]              clear_pc
);

    localparam int DEPTH = 1 << ROB_INDEX_BIT;

    localparam logic [ROB_INDEX_BIT-1:0] PTR_ONE    = ROB_INDEX_BIT'(1);
    localparam logic [ROB_INDEX_BIT:0]   CNT_ONE    = (ROB_INDEX_BIT + 1)'(1);
    localparam logic [ROB_INDEX_BIT:0]   FULL_COUNT = (ROB_INDEX_BIT + 1)'(DEPTH);

    typedef enum logic [1:0] {
        OP_REG    = 2'd0,
        OP_STORE  = 2'd1,
        OP_BRANCH = 2'd2
    } op_type_t;

    // Payload of one entry. Occupancy (busy) and completion (ready) live in
    // separate vectors so the flush can clear them in one step.
    typedef struct packed {
        op_type_t    kind;
        logic [4:0]  rd;
        logic [31:0] value;
        logic        pred_taken;
        logic        taken;
        logic [31:0] target;
    } entry_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [DEPTH-1:0]         busy;
    logic [DEPTH-1:0]         ready;
    entry_t                   entries [DEPTH];
    logic [ROB_INDEX_BIT-1:0] head;
    logic [ROB_INDEX_BIT-1:0] tail;
    logic [ROB_INDEX_BIT:0]   count;

    // -------------------------------------------------------------------------
    // Per-cycle decisions
    // -------------------------------------------------------------------------
    logic                   issue_fire;
    logic                   cdb_hit;
    logic                   commit_fire;
    logic                   head_writes_rd;
    logic                   head_mispredict;
    logic [ROB_INDEX_BIT:0] count_next;
    entry_t                 head_entry;

    assign full         = (count == FULL_COUNT);
    assign issue_rob_id = tail;

    // While clear is high the whole buffer is being flushed, so nothing may
    // be allocated, written back or retired in that cycle.
    assign issue_fire  = issue_valid && !full && !clear;
    assign cdb_hit     = cdb_valid && busy[cdb_rob_id] && !clear;
    assign commit_fire = busy[head] && ready[head] && !clear;

    assign head_entry = entries[head];

    // NOTE: every signal assigned in an always_comb gets a default at the top
    // of the block, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        count_next      = count;
        head_writes_rd  = 1'b0;
        head_mispredict = 1'b0;

        if (issue_fire && !commit_fire) begin
            count_next = count + CNT_ONE;
        end else if (!issue_fire && commit_fire) begin
            count_next = count - CNT_ONE;
        end

        if (head_entry.kind == OP_REG || head_entry.kind == OP_BRANCH) begin
            head_writes_rd = 1'b1;
        end
        if (head_entry.kind == OP_BRANCH && head_entry.taken != head_entry.pred_taken) begin
            head_mispredict = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Operand queries: an entry being written on the CDB this very cycle is
    // forwarded so issue does not wait an extra cycle for the register.
    // -------------------------------------------------------------------------
    always_comb begin
        qry_ready1 = ready[qry_id1];
        qry_value1 = entries[qry_id1].value;
        qry_ready2 = ready[qry_id2];
        qry_value2 = entries[qry_id2].value;

        if (cdb_valid && cdb_rob_id == qry_id1) begin
            qry_ready1 = 1'b1;
            qry_value1 = cdb_value;
        end
        if (cdb_valid && cdb_rob_id == qry_id2) begin
            qry_ready2 = 1'b1;
            qry_value2 = cdb_value;
        end
    end

    // -------------------------------------------------------------------------
    // Control state and registered commit outputs.
    // Issue writes the tail and commit frees the head; the two never coincide
    // because an empty buffer cannot commit and a full one cannot issue.
    // -------------------------------------------------------------------------
    // NOTE: state registers use non-blocking assignments only, so every read
    // in this block sees the value from before the clock edge.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            busy                <= '0;
            ready               <= '0;
            head                <= '0;
            tail                <= '0;
            count               <= '0;
            set_value_id        <= '0;
            set_value           <= '0;
            set_value_rob_id    <= '0;
            commit_store        <= 1'b0;
            commit_store_rob_id <= '0;
            clear               <= 1'b0;
            clear_pc            <= '0;
        end else if (rdy_in) begin
            // Pulse outputs default low; a commit below overrides them.
            set_value_id <= '0;
            commit_store <= 1'b0;
            clear        <= 1'b0;

            if (clear) begin
                busy  <= '0;
                ready <= '0;
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (cdb_hit) begin
                    ready[cdb_rob_id] <= 1'b1;
                end

                if (issue_fire) begin
                    busy[tail]  <= 1'b1;
                    ready[tail] <= issue_ready;
                    tail        <= tail + PTR_ONE;
                end

                if (commit_fire) begin
                    busy[head]  <= 1'b0;
                    ready[head] <= 1'b0;
                    head        <= head + PTR_ONE;

                    if (head_writes_rd) begin
                        set_value_id     <= head_entry.rd;
                        set_value        <= head_entry.value;
                        set_value_rob_id <= head;
                    end
                    if (head_entry.kind == OP_STORE) begin
                        commit_store        <= 1'b1;
                        commit_store_rob_id <= head;
                    end
                    if (head_mispredict) begin
                        clear    <= 1'b1;
                        clear_pc <= head_entry.target;
                    end
                end

                count <= count_next;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Entry payload.
    // NOTE: the payload array has no reset; busy/ready decide whether an entry
    // means anything, so clearing the data itself would only cost reset fanout.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (rdy_in) begin
            if (issue_fire) begin
                // taken starts equal to the prediction so an entry that is
                // complete at issue can never look like a misprediction.
                entries[tail] <= '{
                    kind:       op_type_t'(issue_type),
                    rd:         issue_rd,
                    value:      issue_value,
                    pred_taken: issue_pred_taken,
                    taken:      issue_pred_taken,
                    target:     '0
                };
            end
            if (cdb_hit) begin
                entries[cdb_rob_id].value  <= cdb_value;
                entries[cdb_rob_id].taken  <= cdb_taken;
                entries[cdb_rob_id].target <= cdb_target;
            end
        end
    end

endmodule
